fir_tf_cfg: RTL and testbench

Parametrised transposed-form FIR filter with a runtime-loadable coefficient bank, per-tap runtime product truncation, and a rounded, saturating output stage. The filter pipeline advances only on accepted samples, so the block runs at any sample rate up to the clock rate. It sits in the fixed-point wordlength-optimisation datapath and is the generalised successor of the fixed 30-tap filter. Tap count, all word lengths and the reset coefficient set are parameters.

---
 rtl/fir_tf_cfg_pkg.sv | 55 +++++
 rtl/fir_tap_trunc.sv | 26 ++
 rtl/fir_tf_cfg.sv | 159 +++++++++++++++
 tb/tb_fir_tf_cfg.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tf_cfg_pkg.sv
// Shared definitions for the configurable transposed-form FIR: width helpers,
// FSM encoding and the rounded/saturating output conversion.
package fir_cfg_pkg;

    localparam int FRAC_WL_W = 8;
    localparam int WIDE_W    = 128;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } fir_state_e;

    typedef struct packed {
        logic signed [WIDE_W-1:0] value;
        logic                     sat;
    } round_sat_t;

    function automatic int calc_prod_w(input int coe_w, input int in_w);
        return coe_w + in_w;
    endfunction

    function automatic int calc_acc_w(input int prod_w, input int n_taps);
        return prod_w + $clog2(n_taps);
    endfunction

    // Drops 'shift' fraction bits with half-up rounding, then clamps to a signed out_w range
    function automatic round_sat_t round_sat(input logic signed [WIDE_W-1:0] acc,
                                             input int shift, input int out_w);
        logic signed [WIDE_W-1:0] one;
        logic signed [WIDE_W-1:0] rounded;
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        round_sat_t               res;
        one = {{(WIDE_W-1){1'b0}}, 1'b1};
        if (shift > 0) begin
            rounded = (acc + (one <<< (shift - 1))) >>> shift;
        end else begin
            rounded = acc <<< (-shift);
        end
        max_v     = (one <<< (out_w - 1)) - one;
        min_v     = -(one <<< (out_w - 1));
        res.value = rounded;
        res.sat   = 1'b0;
        if (rounded > max_v) begin
            res.value = max_v;
            res.sat   = 1'b1;
        end else if (rounded < min_v) begin
            res.value = min_v;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_tap_trunc.sv
// Per-tap product truncation: clears product bits below 2^-frac_wl, or passes
// the product untouched when frac_wl covers every fractional bit.
module fir_tap_trunc
    import fir_cfg_pkg::*;
#(
    parameter int PROD_W    = 32,
    parameter int PROD_FRAC = 24
) (
    input  logic signed [PROD_W-1:0]    prod_in,
    input  logic        [FRAC_WL_W-1:0] frac_wl,
    output logic signed [PROD_W-1:0]    prod_out
);

    logic [PROD_W-1:0] keep_mask;

    always_comb begin
        keep_mask = '1;
        if (int'(frac_wl) < PROD_FRAC) begin
            keep_mask = keep_mask << (PROD_FRAC - int'(frac_wl));
        end
    end

    // Clearing low bits of a two's-complement value rounds toward minus infinity
    assign prod_out = prod_in & keep_mask;

endmodule

// File: rtl/fir_tf_cfg.sv
// Transposed-form FIR with a runtime-loadable coefficient bank, per-tap product
// truncation and a rounded, saturating registered output.
module fir_tf_cfg
    import fir_cfg_pkg::*;
#(
    parameter int N_TAPS      = 30,
    parameter int COE_INTE_WL = 4,
    parameter int COE_FRAC_WL = 12,
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 12,
    parameter int OUT_INTE_WL = 4,
    parameter int OUT_FRAC_WL = 12,
    parameter logic [COE_INTE_WL+COE_FRAC_WL-1:0] COE_INIT [0:N_TAPS-1] =
        '{0: {{(COE_INTE_WL-1){1'b0}}, 1'b1, {COE_FRAC_WL{1'b0}}}, default: '0}
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_TAPS-1:0][FRAC_WL_W-1:0]        frac_wl,
    input  logic                                    coe_load,
    input  logic                                    coe_valid,
    input  logic signed [COE_INTE_WL+COE_FRAC_WL-1:0] coe_data,
    output logic                                    in_ready,
    input  logic                                    in_valid,
    input  logic signed [IN_INTE_WL+IN_FRAC_WL-1:0] data_in,
    output logic signed [OUT_INTE_WL+OUT_FRAC_WL-1:0] data_out,
    output logic                                    out_valid,
    output logic                                    out_sat
);

    localparam int COE_W     = COE_INTE_WL + COE_FRAC_WL;
    localparam int IN_W      = IN_INTE_WL + IN_FRAC_WL;
    localparam int OUT_W     = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int PROD_W    = calc_prod_w(COE_W, IN_W);
    localparam int PROD_FRAC = COE_FRAC_WL + IN_FRAC_WL;
    localparam int ACC_W     = calc_acc_w(PROD_W, N_TAPS);
    localparam int IDX_W     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    fir_state_e                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [COE_W-1:0]   coe_q [N_TAPS];
    logic signed [COE_W-1:0]   coe_d [N_TAPS];
    logic signed [ACC_W-1:0]   sum_q [N_TAPS];
    logic signed [ACC_W-1:0]   sum_d [N_TAPS];
    logic signed [PROD_W-1:0]  prod [N_TAPS];
    logic signed [PROD_W-1:0]  tprod [N_TAPS];
    logic signed [ACC_W-1:0]   tprod_ext [N_TAPS];
    logic [PROD_W-1:0]         data_ext;
    logic                      accept;
    logic                      acc_v_q, acc_v_d;
    logic signed [OUT_W-1:0]   data_out_q, data_out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_sat_q, out_sat_d;
    round_sat_t                rs;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid && in_ready;
    assign data_ext = {{COE_W{data_in[IN_W-1]}}, data_in};

    for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
        assign prod[i] = {{IN_W{coe_q[i][COE_W-1]}}, coe_q[i]} * data_ext;
        fir_tap_trunc #(
            .PROD_W   (PROD_W),
            .PROD_FRAC(PROD_FRAC)
        ) u_trunc (
            .prod_in (prod[i]),
            .frac_wl (frac_wl[i]),
            .prod_out(tprod[i])
        );
        assign tprod_ext[i] = {{(ACC_W-PROD_W){tprod[i][PROD_W-1]}}, tprod[i]};
    end

    // Coefficient reload: a new coe_load in LOAD restarts the write index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        coe_d   = coe_q;
        case (state_q)
            RUN: begin
                if (coe_load) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (coe_load) begin
                    idx_d = '0;
                end else if (coe_valid) begin
                    coe_d[idx_q] = coe_data;
                    if (idx_q == IDX_W'(N_TAPS - 1)) begin
                        state_d = FLUSH;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        sum_d   = sum_q;
        acc_v_d = accept;
        if (state_q == FLUSH) begin
            for (int i = 0; i < N_TAPS; i++) sum_d[i] = '0;
            acc_v_d = 1'b0;
        end else if (accept) begin
            for (int i = 0; i < N_TAPS - 1; i++) sum_d[i] = tprod_ext[i] + sum_q[i+1];
            sum_d[N_TAPS-1] = tprod_ext[N_TAPS-1];
        end
    end

    always_comb begin
        rs          = round_sat({{(WIDE_W-ACC_W){sum_q[0][ACC_W-1]}}, sum_q[0]},
                                PROD_FRAC - OUT_FRAC_WL, OUT_W);
        data_out_d  = data_out_q;
        out_sat_d   = out_sat_q;
        out_valid_d = acc_v_q;
        if (state_q == FLUSH) begin
            data_out_d  = '0;
            out_sat_d   = 1'b0;
            out_valid_d = 1'b0;
        end else if (acc_v_q) begin
            data_out_d = rs.value[OUT_W-1:0];
            out_sat_d  = rs.sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            idx_q       <= '0;
            acc_v_q     <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                coe_q[i] <= COE_INIT[i];
                sum_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_v_q     <= acc_v_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            for (int i = 0; i < N_TAPS; i++) begin
                coe_q[i] <= coe_d[i];
                sum_q[i] <= sum_d[i];
            end
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_tf_cfg.sv
// Directed, table-driven bench for fir_tf_cfg with hand-computed expectations.
module tb_fir_tf_cfg;

    localparam int N_TAPS = 30;

    logic                          clk;
    logic                          rst;
    logic [N_TAPS-1:0][7:0]        frac_wl;
    logic                          coe_load;
    logic                          coe_valid;
    logic signed [15:0]            coe_data;
    logic                          in_ready;
    logic                          in_valid;
    logic signed [15:0]            data_in;
    logic signed [15:0]            data_out;
    logic                          out_valid;
    logic                          out_sat;

    int testsRun;
    int testsFailed;

    // One record per input cycle; expectations describe the output this cycle produces
    typedef struct {
        logic        in_valid;
        logic [15:0] data_in;
        logic [7:0]  frac0;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] coeBuf [N_TAPS];

    fir_tf_cfg #(.N_TAPS(N_TAPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .frac_wl  (frac_wl),
        .coe_load (coe_load),
        .coe_valid(coe_valid),
        .coe_data (coe_data),
        .in_ready (in_ready),
        .in_valid (in_valid),
        .data_in  (data_in),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_sat  (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid   = v.in_valid;
        data_in    = v.data_in;
        frac_wl[0] = v.frac0;
    endtask

    task automatic addVec(input logic iv, input logic [15:0] d, input logic [7:0] f0,
                          input logic [15:0] ed, input logic es);
        vec_t v;
        v.in_valid = iv;
        v.data_in  = d;
        v.frac0    = f0;
        v.exp_data = ed;
        v.exp_sat  = es;
        vecs.push_back(v);
    endtask

    task automatic runTable(input string name);
        int n;
        vec_t idle;
        n = vecs.size();
        idle.in_valid = 1'b0;
        idle.data_in  = 16'h0000;
        idle.frac0    = 8'd24;
        idle.exp_data = 16'h0000;
        idle.exp_sat  = 1'b0;
        for (int j = 0; j <= n; j++) begin
            if (j < n) applyStimulus(vecs[j]);
            else applyStimulus(idle);
            step();
            if (j > 0) begin
                checkOutput($sformatf("%s[%0d].valid", name, j - 1), 16'(out_valid),
                            16'(vecs[j-1].in_valid));
                checkOutput($sformatf("%s[%0d].data", name, j - 1), data_out,
                            vecs[j-1].exp_data);
                checkOutput($sformatf("%s[%0d].sat", name, j - 1), 16'(out_sat),
                            16'(vecs[j-1].exp_sat));
            end
        end
        vecs.delete();
    endtask

    task automatic loadCoeffs(input string name);
        in_valid = 1'b0;
        coe_load = 1'b1;
        step();
        coe_load = 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
            coe_valid = 1'b1;
            coe_data  = coeBuf[i];
            step();
        end
        coe_valid = 1'b0;
        step();
        checkOutput({name, ".ready_after_flush"}, 16'(in_ready), 16'h1);
    endtask

    initial begin
        int e;
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        coe_load    = 1'b0;
        coe_valid   = 1'b0;
        coe_data    = '0;
        in_valid    = 1'b0;
        data_in     = '0;
        for (int i = 0; i < N_TAPS; i++) frac_wl[i] = 8'd24;

        // Reset state
        step();
        step();
        checkOutput("reset.data", data_out, 16'h0000);
        checkOutput("reset.valid", 16'(out_valid), 16'h0);
        checkOutput("reset.sat", 16'(out_sat), 16'h0);
        rst = 1'b0;
        step();
        checkOutput("reset.ready", 16'(in_ready), 16'h1);

        // Identity bank out of reset, with gaps and full-scale values
        addVec(1, 16'h1000, 24, 16'h1000, 0);
        addVec(1, 16'h0000, 24, 16'h0000, 0);
        addVec(0, 16'h0000, 24, 16'h0000, 0);
        addVec(1, 16'hF000, 24, 16'hF000, 0);
        addVec(0, 16'h1234, 24, 16'hF000, 0);
        addVec(1, 16'h7FFF, 24, 16'h7FFF, 0);
        addVec(1, 16'h8000, 24, 16'h8000, 0);
        runTable("identity");

        // Truncation of tap 0 product
        addVec(1, 16'h1800, 0,  16'h1000, 0);
        addVec(1, 16'h1800, 24, 16'h1800, 0);
        addVec(1, 16'h1801, 12, 16'h1801, 0);
        addVec(1, 16'h1801, 11, 16'h1800, 0);
        addVec(1, 16'hE800, 0,  16'hE000, 0);
        addVec(1, 16'h1801, 30, 16'h1801, 0);
        runTable("trunc");

        // Ramp bank: impulse response, then half-up rounding of +/-0.5 impulses
        for (int i = 0; i < N_TAPS; i++) coeBuf[i] = 16'(i + 1);
        loadCoeffs("ramp");
        for (int j = 0; j <= N_TAPS; j++)
            addVec(1, (j == 0) ? 16'h1000 : 16'h0000, 24, (j < N_TAPS) ? 16'(j + 1) : 16'h0, 0);
        for (int j = 0; j <= N_TAPS; j++)
            addVec(1, (j == 0) ? 16'h0800 : 16'h0000, 24, (j < N_TAPS) ? 16'((j + 2) >> 1) : 16'h0, 0);
        for (int j = 0; j <= N_TAPS; j++) begin
            e = -((j + 1) >> 1);
            addVec(1, (j == 0) ? 16'hF800 : 16'h0000, 24, (j < N_TAPS) ? 16'(e) : 16'h0, 0);
        end
        runTable("ramp");

        // History for the flush check
        addVec(1, 16'h1000, 24, 16'h0001, 0);
        addVec(1, 16'h1000, 24, 16'h0003, 0);
        addVec(1, 16'h1000, 24, 16'h0006, 0);
        runTable("history");

        // coe_load together with a valid sample: the sample is still taken
        coe_load = 1'b1;
        in_valid = 1'b1;
        data_in  = 16'h1000;
        step();
        coe_load = 1'b0;
        checkOutput("hs.ready_load", 16'(in_ready), 16'h0);
        checkOutput("hs.valid_a", 16'(out_valid), 16'h0);
        for (int i = 0; i < N_TAPS; i++) begin
            coe_valid = 1'b1;
            coe_data  = (i == 0) ? 16'h1000 : 16'h0000;
            step();
            checkOutput($sformatf("hs.ready[%0d]", i), 16'(in_ready), 16'h0);
            if (i == 0) begin
                checkOutput("hs.valid_last", 16'(out_valid), 16'h1);
                checkOutput("hs.data_last", data_out, 16'h000A);
            end else begin
                checkOutput($sformatf("hs.valid[%0d]", i), 16'(out_valid), 16'h0);
            end
        end
        coe_valid = 1'b0;
        data_in   = 16'h0400;
        step();
        checkOutput("hs.ready_run", 16'(in_ready), 16'h1);
        checkOutput("hs.flush_valid", 16'(out_valid), 16'h0);
        checkOutput("hs.flush_data", data_out, 16'h0000);
        step();
        in_valid = 1'b0;
        step();
        checkOutput("hs.post_valid", 16'(out_valid), 16'h1);
        checkOutput("hs.post_data", data_out, 16'h0400);

        // Saturation with all taps at 0.5
        for (int i = 0; i < N_TAPS; i++) coeBuf[i] = 16'h0800;
        loadCoeffs("half_pos");
        for (int j = 0; j < 32; j++)
            addVec(1, 16'h7FFF, 24, (j == 0) ? 16'h4000 : 16'h7FFF, (j >= 2) ? 1'b1 : 1'b0);
        runTable("sat_pos");
        loadCoeffs("half_neg");
        for (int j = 0; j < 32; j++)
            addVec(1, 16'h8000, 24, (j == 0) ? 16'hC000 : 16'h8000, (j >= 2) ? 1'b1 : 1'b0);
        runTable("sat_neg");

        // Reset in the middle of a reload
        coe_load = 1'b1;
        step();
        coe_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            coe_valid = 1'b1;
            coe_data  = 16'h0800;
            step();
        end
        rst = 1'b1;
        #1;
        checkOutput("midload_rst.ready", 16'(in_ready), 16'h1);
        checkOutput("midload_rst.data", data_out, 16'h0000);
        checkOutput("midload_rst.sat", 16'(out_sat), 16'h0);
        coe_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        addVec(1, 16'h1000, 24, 16'h1000, 0);
        addVec(1, 16'h0000, 24, 16'h0000, 0);
        runTable("midload_identity");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
